// File: rtl/ttt_game_ctrl_if.sv
// Move handshake and game status bundle for the N x N game controller.
// Master drives moves and new_game; slave returns board and status.
interface ttt_game_ctrl_if #(
  parameter int N = 3
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = $clog2(N*N+1);

  logic          new_game;
  logic          move_valid;
  logic          move_ready;
  logic [CW-1:0] move_row;
  logic [CW-1:0] move_col;
  logic          move_err;
  logic          turn;
  logic [2*N*N-1:0] board;
  logic [MW-1:0] move_count;
  logic          wina;
  logic          winb;
  logic          draw;
  logic          game_over;

  modport master (
    output new_game, move_valid, move_row, move_col,
    input  move_ready, move_err, turn, board,
    input  move_count, wina, winb, draw, game_over
  );

  modport slave (
    input  new_game, move_valid, move_row, move_col,
    output move_ready, move_err, turn, board,
    output move_count, wina, winb, draw, game_over
  );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Registered N x N, K-in-a-row game controller.
// Accepts moves, rejects illegal ones, scans all windows one cycle later.
module ttt_game_ctrl #(
  parameter int N = 3,
  parameter int K = N
) (
  input logic            clk,
  input logic            rst,
  ttt_game_ctrl_if.slave bus
);
  localparam int MW = $clog2(N*N+1);
  localparam int NN = N*N;
  localparam int BW = 2*NN;
  localparam int unsigned NU = N;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    OVER
  } state_t;

  state_t state_q, state_d;

  logic [BW-1:0] board_q, board_d;
  logic [MW-1:0] cnt_q, cnt_d;
  logic          turn_q, turn_d;
  logic          wina_q, wina_d;
  logic          winb_q, winb_d;
  logic          draw_q, draw_d;
  logic          err_q, err_d;

  logic          fire;
  logic          in_range;
  logic          legal;
  logic          full;
  logic          line_a;
  logic          line_b;
  logic          mover_win;
  logic [1:0]    sel_cell;
  logic [1:0]    mark;
  int unsigned   row_i;
  int unsigned   col_i;
  int unsigned   idx;

  // Off-board coordinates read as empty so windows running
  // past an edge can never match a player.
  function automatic logic [1:0] cell_at(
    input logic [BW-1:0] b,
    input int            r,
    input int            c
  );
    logic [BW-1:0] s;
    if (r < 0 || r >= N || c < 0 || c >= N) return 2'b00;
    s = b >> (2*(r*N+c));
    return s[1:0];
  endfunction

  // Any K-long row, column, diagonal or anti-diagonal owned by p.
  function automatic logic has_line(
    input logic [BW-1:0] b,
    input logic [1:0]    p
  );
    logic hit;
    logic all;
    int   dr;
    int   dc;
    hit = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        for (int d = 0; d < 4; d++) begin
          dr  = (d == 0) ? 0 : 1;
          dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
          all = 1'b1;
          for (int k = 0; k < K; k++)
            all = all & (cell_at(b, r+k*dr, c+k*dc) == p);
          hit = hit | all;
        end
      end
    end
    return hit;
  endfunction

  // Move decode: range, target cell and legality.
  always_comb begin
    row_i    = 32'(bus.move_row);
    col_i    = 32'(bus.move_col);
    idx      = row_i*NU + col_i;
    in_range = (row_i < NU) && (col_i < NU);
    sel_cell = 2'(board_q >> (2*idx));
    legal    = in_range && (sel_cell == 2'b00);
    fire     = bus.move_valid && (state_q == IDLE);
    mark     = turn_q ? 2'b10 : 2'b01;
    full     = (cnt_q == MW'(NN));
  end

  // Window scan of the board written on the previous edge.
  always_comb begin
    line_a    = has_line(board_q, 2'b01);
    line_b    = has_line(board_q, 2'b10);
    mover_win = turn_q ? line_b : line_a;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; new_game overrides everything.
  always_comb begin
    state_d = state_q;
    if (bus.new_game) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (fire && legal) state_d = CHECK;
        CHECK:   state_d = (mover_win || full) ? OVER : IDLE;
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: board write, flags, turn, error pulse.
  always_comb begin
    board_d = board_q;
    cnt_d   = cnt_q;
    turn_d  = turn_q;
    wina_d  = wina_q;
    winb_d  = winb_q;
    draw_d  = draw_q;
    err_d   = 1'b0;
    if (bus.new_game) begin
      board_d = '0;
      cnt_d   = '0;
      turn_d  = 1'b0;
      wina_d  = 1'b0;
      winb_d  = 1'b0;
      draw_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fire) begin
            if (legal) begin
              board_d = board_q | (BW'(mark) << (2*idx));
              cnt_d   = cnt_q + MW'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (mover_win) begin
            if (turn_q) winb_d = 1'b1;
            else        wina_d = 1'b1;
          end else if (full) begin
            draw_d = 1'b1;
          end else begin
            turn_d = ~turn_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_q <= '0;
      cnt_q   <= '0;
      turn_q  <= 1'b0;
      wina_q  <= 1'b0;
      winb_q  <= 1'b0;
      draw_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      board_q <= board_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      wina_q  <= wina_d;
      winb_q  <= winb_d;
      draw_q  <= draw_d;
      err_q   <= err_d;
    end
  end

  assign bus.move_ready = (state_q == IDLE);
  assign bus.move_err   = err_q;
  assign bus.turn       = turn_q;
  assign bus.board      = board_q;
  assign bus.move_count = cnt_q;
  assign bus.wina       = wina_q;
  assign bus.winb       = winb_q;
  assign bus.draw       = draw_q;
  assign bus.game_over  = wina_q | winb_q | draw_q;
endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: 3x3 (K=3) and 5x5 (K=4) instances
// checked every cycle against a board-level game model.
module tb_ttt_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       mv  [2];
  logic       mng [2];
  logic [2:0] mr  [2];
  logic [2:0] mc  [2];

  logic [127:0] o_board [2];
  logic [127:0] o_cnt   [2];
  logic         o_rdy   [2];
  logic         o_err   [2];
  logic         o_turn  [2];
  logic         o_wa    [2];
  logic         o_wb    [2];
  logic         o_dr    [2];
  logic         o_go    [2];

  ttt_game_ctrl_if #(.N(3)) if3 ();
  ttt_game_ctrl_if #(.N(5)) if5 ();

  ttt_game_ctrl #(.N(3), .K(3)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  ttt_game_ctrl #(.N(5), .K(4)) u5 (
    .clk (clk),
    .rst (rst),
    .bus (if5)
  );

  assign if3.new_game   = mng[0];
  assign if3.move_valid = mv[0];
  assign if3.move_row   = mr[0][1:0];
  assign if3.move_col   = mc[0][1:0];
  assign if5.new_game   = mng[1];
  assign if5.move_valid = mv[1];
  assign if5.move_row   = mr[1];
  assign if5.move_col   = mc[1];

  assign o_board[0] = 128'(if3.board);
  assign o_cnt[0]   = 128'(if3.move_count);
  assign o_rdy[0]   = if3.move_ready;
  assign o_err[0]   = if3.move_err;
  assign o_turn[0]  = if3.turn;
  assign o_wa[0]    = if3.wina;
  assign o_wb[0]    = if3.winb;
  assign o_dr[0]    = if3.draw;
  assign o_go[0]    = if3.game_over;
  assign o_board[1] = 128'(if5.board);
  assign o_cnt[1]   = 128'(if5.move_count);
  assign o_rdy[1]   = if5.move_ready;
  assign o_err[1]   = if5.move_err;
  assign o_turn[1]  = if5.turn;
  assign o_wa[1]    = if5.wina;
  assign o_wb[1]    = if5.winb;
  assign o_dr[1]    = if5.draw;
  assign o_go[1]    = if5.game_over;

  // Game model: 2-D board of player numbers (0 empty, 1 A, 2 B).
  int mN [2] = '{3, 5};
  int mK [2] = '{3, 4};
  int mb [2][8][8];
  int mturn [2];
  int mcnt  [2];
  int mwa   [2];
  int mwb   [2];
  int mdr   [2];
  int merr  [2];
  int mph   [2];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic mclear(input int i);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mb[i][r][c] = 0;
    mturn[i] = 0;
    mcnt[i]  = 0;
    mwa[i]   = 0;
    mwb[i]   = 0;
    mdr[i]   = 0;
    merr[i]  = 0;
    mph[i]   = 0;
  endtask

  // Longest run of p from each cell in each direction vs K.
  function automatic bit mwins(input int i, input int p);
    int drs [4] = '{0, 1, 1, 1};
    int dcs [4] = '{1, 0, 1, -1};
    int n = mN[i];
    int run;
    int rr;
    int cc;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          run = 0;
          rr  = r;
          cc  = c;
          while (rr >= 0 && rr < n && cc >= 0 && cc < n &&
                 mb[i][rr][cc] == p) begin
            run++;
            rr += drs[d];
            cc += dcs[d];
          end
          if (run >= mK[i]) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic logic [127:0] mboard(input int i);
    logic [127:0] v = '0;
    int n = mN[i];
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        v[2*(r*n+c)+:2] = 2'(mb[i][r][c]);
    return v;
  endfunction

  task automatic mstep(input int i);
    int r;
    int c;
    int p;
    merr[i] = 0;
    p = (mturn[i] != 0) ? 2 : 1;
    if (mng[i]) begin
      mclear(i);
    end else if (mph[i] == 1) begin
      if (mwins(i, p)) begin
        if (p == 1) mwa[i] = 1;
        else        mwb[i] = 1;
        mph[i] = 2;
      end else if (mcnt[i] == mN[i]*mN[i]) begin
        mdr[i] = 1;
        mph[i] = 2;
      end else begin
        mturn[i] = 1 - mturn[i];
        mph[i]   = 0;
      end
    end else if (mph[i] == 0 && mv[i]) begin
      r = int'(mr[i]);
      c = int'(mc[i]);
      if (r >= mN[i] || c >= mN[i]) merr[i] = 1;
      else if (mb[i][r][c] != 0)    merr[i] = 1;
      else begin
        mb[i][r][c] = p;
        mcnt[i]++;
        mph[i] = 1;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) mclear(i);
      else     mstep(i);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready%0d", i), 128'(o_rdy[i]), 128'(mph[i] == 0));
        chk($sformatf("err%0d", i),   128'(o_err[i]), 128'(merr[i]));
        chk($sformatf("turn%0d", i),  128'(o_turn[i]), 128'(mturn[i]));
        chk($sformatf("board%0d", i), o_board[i], mboard(i));
        chk($sformatf("count%0d", i), o_cnt[i], 128'(mcnt[i]));
        chk($sformatf("wina%0d", i),  128'(o_wa[i]), 128'(mwa[i]));
        chk($sformatf("winb%0d", i),  128'(o_wb[i]), 128'(mwb[i]));
        chk($sformatf("draw%0d", i),  128'(o_dr[i]), 128'(mdr[i]));
        chk($sformatf("over%0d", i),  128'(o_go[i]),
            128'((mwa[i] | mwb[i] | mdr[i]) != 0));
      end
    end
  end

  int err_seen = 0;
  always @(negedge clk) if (!rst && o_err[0]) err_seen++;

  task automatic move(input int i, input int r, input int c);
    @(negedge clk); #1;
    mv[i] = 1'b1;
    mr[i] = 3'(r);
    mc[i] = 3'(c);
    @(negedge clk); #1;
    mv[i] = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic new_game(input int i);
    @(negedge clk); #1;
    mng[i] = 1'b1;
    @(negedge clk); #1;
    mng[i] = 1'b0;
  endtask

  int t4 [18] = '{0,0, 0,1, 0,2, 1,1, 1,0, 1,2, 2,1, 2,0, 2,2};

  initial begin
    for (int i = 0; i < 2; i++) begin
      mv[i]  = 1'b0;
      mng[i] = 1'b0;
      mr[i]  = '0;
      mc[i]  = '0;
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_board", o_board[0], 128'h0);
    chk("rst_ready", 128'(o_rdy[0]), 128'h1);

    // Row win for A on row 0.
    move(0, 0, 0); move(0, 1, 0); move(0, 0, 1);
    move(0, 1, 1); move(0, 0, 2);
    chk("t1_wina", 128'(o_wa[0]), 128'h1);
    chk("t1_over", 128'(o_go[0]), 128'h1);
    chk("t1_count", o_cnt[0], 128'd5);
    chk("t1_winb", 128'(o_wb[0]), 128'h0);
    chk("t1_ready", 128'(o_rdy[0]), 128'h0);

    // Anti-diagonal for B.
    new_game(0);
    move(0, 0, 0); move(0, 0, 2); move(0, 0, 1);
    move(0, 1, 1); move(0, 2, 2); move(0, 2, 0);
    chk("t2_winb", 128'(o_wb[0]), 128'h1);
    chk("t2_turn", 128'(o_turn[0]), 128'h1);
    chk("t2_cell6", 128'(o_board[0][13:12]), 128'h2);

    // Occupied cell and off-board row are rejected.
    new_game(0);
    err_seen = 0;
    move(0, 1, 1); move(0, 1, 1); move(0, 3, 0);
    chk("t3_errs", 128'(err_seen), 128'd2);
    chk("t3_turn", 128'(o_turn[0]), 128'h1);
    chk("t3_count", o_cnt[0], 128'd1);
    chk("t3_board", o_board[0], 128'h100);

    // Full board with no line.
    new_game(0);
    for (int m = 0; m < 9; m++) move(0, t4[2*m], t4[2*m+1]);
    chk("t4_draw", 128'(o_dr[0]), 128'h1);
    chk("t4_wins", 128'({o_wa[0], o_wb[0]}), 128'h0);
    chk("t4_count", o_cnt[0], 128'd9);

    // 5x5, four on the diagonal (1,1)-(4,4).
    move(1, 1, 1); move(1, 0, 4); move(1, 2, 2); move(1, 4, 0);
    move(1, 3, 3);
    chk("t5_nowin", 128'(o_wa[1]), 128'h0);
    move(1, 0, 2); move(1, 4, 4);
    chk("t5_wina", 128'(o_wa[1]), 128'h1);
    chk("t5_count", o_cnt[1], 128'd7);
    move(1, 2, 3);
    chk("t5_ready", 128'(o_rdy[1]), 128'h0);
    chk("t5_count2", o_cnt[1], 128'd7);
    new_game(1);
    chk("t5_clear", o_board[1], 128'h0);
    chk("t5_clrwin", 128'(o_go[1]), 128'h0);

    // Asynchronous reset while in CHECK.
    new_game(0);
    @(negedge clk); #1;
    mv[0] = 1'b1; mr[0] = 3'd0; mc[0] = 3'd0;
    @(posedge clk); #1;
    mv[0] = 1'b0;
    chk("t6_pre", o_board[0], 128'h1);
    chk("t6_chk", 128'(o_rdy[0]), 128'h0);
    rst = 1'b1;
    #1;
    chk("t6_board", o_board[0], 128'h0);
    chk("t6_count", o_cnt[0], 128'h0);
    chk("t6_ready", 128'(o_rdy[0]), 128'h1);
    @(negedge clk); #1;
    rst = 1'b0;

    // new_game lands on the CHECK cycle of a winning move.
    move(0, 0, 0); move(0, 1, 0); move(0, 0, 1); move(0, 1, 1);
    @(negedge clk); #1;
    mv[0] = 1'b1; mr[0] = 3'd0; mc[0] = 3'd2;
    @(negedge clk); #1;
    mv[0] = 1'b0; mng[0] = 1'b1;
    @(negedge clk); #1;
    mng[0] = 1'b0;
    chk("t6_wina", 128'(o_wa[0]), 128'h0);
    chk("t6_empty", o_board[0], 128'h0);
    chk("t6_idle", 128'(o_rdy[0]), 128'h1);
    chk("t6_turn", 128'(o_turn[0]), 128'h0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
